// File: rtl/aes_core.sv
// rtl/aes_core.sv - iterative AES-128/192/256 block cipher, one round per clock
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     block handshake; in_ready is high only while IDLE
//   in_data[127:0]        plaintext or ciphertext, byte 0 in [127:120], column-major
//   in_decrypt            1 selects the inverse cipher (ignored when ENABLE_DEC == 0)
//   in_keylen[1:0]        0/3 = AES-128, 1 = AES-192, 2 = AES-256
//   rk_idx[3:0]           index of the round key needed this cycle
//   round_key[127:0]      w[rk_idx], supplied combinationally by the key schedule
//   out_valid/out_ready   result handshake; out_data held while stalled
//   out_data[127:0]       result register
//   busy                  high while a block is being processed
module aes_core #(
    parameter int ENABLE_DEC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_decrypt,
    input  logic [1:0]   in_keylen,
    output logic [3:0]   rk_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic {IDLE, ROUND} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    // State byte i (row i%4, column i/4) lives at bits [8*(15-i) +: 8].
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[8*(15-i) +: 8] = inv ? inv_sbox(s[8*(15-i) +: 8]) : sbox(s[8*(15-i) +: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns (right by r for the inverse).
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                src = inv ? (c + 4 - rr) % 4 : (c + rr) % 4;
                o[8*(15-(4*c+rr)) +: 8] = s[8*(15-(4*src+rr)) +: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            if (inv) begin
                o[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                o[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                o[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                o[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end else begin
                o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return o;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    state_t       state, state_nxt;
    logic [127:0] stm;
    logic [3:0]   r;
    logic [3:0]   nr;
    logic         dec;

    logic         dec_in;
    logic [3:0]   nr_in;
    logic         fin;
    logic         stall;
    logic         done;
    logic [127:0] enc_sr;
    logic [127:0] dec_ak;
    logic [127:0] round_out;

    assign dec_in = (ENABLE_DEC != 0) && in_decrypt;
    assign nr_in  = nr_of(in_keylen);
    assign fin    = dec ? (r == 4'd0) : (r == nr);
    // A finished block may not overwrite a result the consumer has not taken.
    assign stall  = out_valid && !out_ready;
    assign done   = (state == ROUND) && fin && !stall;

    assign enc_sr = shift_rows(sub_bytes(stm, 1'b0), 1'b0);
    assign dec_ak = sub_bytes(shift_rows(stm, 1'b1), 1'b1) ^ round_key;

    always_comb begin
        round_out = '0;
        if (dec)
            round_out = fin ? dec_ak : mix_columns(dec_ak, 1'b1);
        else
            round_out = fin ? (enc_sr ^ round_key) : (mix_columns(enc_sr, 1'b0) ^ round_key);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROUND;
            ROUND:   if (fin && !stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == ROUND);
        rk_idx   = (state == ROUND) ? r : (dec_in ? nr_in : 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stm <= '0;
            r   <= 4'd0;
            nr  <= 4'd10;
            dec <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            stm <= in_data ^ round_key;
            dec <= dec_in;
            nr  <= nr_in;
            r   <= dec_in ? nr_in - 4'd1 : 4'd1;
        end else if (state == ROUND && !fin) begin
            stm <= round_out;
            r   <= dec ? r - 4'd1 : r + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_data  <= round_out;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_core.sv
// tb/tb_aes_core.sv - scoreboard testbench for aes_core with an external key schedule
`timescale 1ns/1ps
module tb_aes_core;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_decrypt = 1'b0;
    logic [1:0]   in_keylen = 2'd0;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    aes_core #(.ENABLE_DEC(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_decrypt(in_decrypt), .in_keylen(in_keylen),
        .rk_idx(rk_idx), .round_key(round_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab [16];
    logic [2047:0] sbox_vec;

    always_comb round_key = rk_tab[rk_idx];

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j < 16; j++)
            rk_tab[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : 128'h0;
    endtask

    typedef struct {
        logic [127:0] data;
        int           nr;
        bit           chk_lat;
        int           acc;
    } exp_t;
    exp_t sb[$];

    int exp_r = 0;
    int cur_nr = 10;
    bit cur_dec = 1'b0;
    int last_acc = 0;

    task automatic send(input logic [127:0] d, input bit dec, input logic [1:0] kl,
                        input logic [127:0] exp, input bit chk_lat);
        int nr;
        bit ok;
        exp_t e;
        nr = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
        ok = 1'b0;
        in_data = d; in_decrypt = dec; in_keylen = kl; in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                check_eq("rk_idx_idle", 128'(rk_idx), 128'(dec ? nr : 0));
                e.data = exp; e.nr = nr; e.chk_lat = chk_lat; e.acc = cyc + 1;
                sb.push_back(e);
                last_acc = cyc + 1;
                cur_dec = dec; cur_nr = nr; exp_r = dec ? nr - 1 : 1;
            end
        end
        if (!ok) check_eq("accept_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_data    = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt = 1'($urandom);
        in_keylen  = 2'($urandom);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !out_valid && !busy) ok = 1'b1;
        end
        if (!ok) check_eq("drain_timeout", 128'(0), 128'(1));
    endtask

    bit           ov_prev = 1'b0;
    bit           hs_prev = 1'b0;
    logic [127:0] prev_data = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   fin;
        if (reset) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (busy) begin
                check_eq("rk_idx", 128'(rk_idx), 128'(exp_r));
                fin = cur_dec ? (exp_r == 0) : (exp_r == cur_nr);
                if (!fin) exp_r = cur_dec ? exp_r - 1 : exp_r + 1;
            end
            if (out_valid && (!ov_prev || hs_prev)) begin
                if (sb.size() == 0)
                    check_eq("spurious_out_valid", 128'(1), 128'(0));
                else if (sb[0].chk_lat)
                    check_eq("latency", 128'(cyc - sb[0].acc), 128'(sb[0].nr));
            end
            if (out_valid && ov_prev && !hs_prev)
                check_eq("hold_data", out_data, prev_data);
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("out_data", out_data, e.data);
            end
            ov_prev   = out_valid;
            hs_prev   = out_valid && out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  a1;
        bit  ok;
        sbox_vec = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_vec[2047-8*i -: 8];
        load_key(KEY128, 4);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("reset_in_ready", 128'(in_ready), 128'(1));
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_out_valid", 128'(out_valid), 128'(0));
        check_eq("reset_out_data", out_data, 128'h0);
        check_eq("reset_rk_idx", 128'(rk_idx), 128'(0));
        @(posedge clk); #1;

        send(PT, 1'b0, 2'd0, CT128, 1'b1); wait_drain();
        send(CT128, 1'b1, 2'd0, PT, 1'b1); wait_drain();
        load_key(KEY192, 6);
        send(PT, 1'b0, 2'd1, CT192, 1'b1); wait_drain();
        send(CT192, 1'b1, 2'd1, PT, 1'b1); wait_drain();
        load_key(KEY256, 8);
        send(PT, 1'b0, 2'd2, CT256, 1'b1); wait_drain();
        send(CT256, 1'b1, 2'd2, PT, 1'b1); wait_drain();

        // Back-to-back with a blocked consumer: second block must park in its final round.
        load_key(KEY128, 4);
        out_ready = 1'b0;
        send(PT, 1'b0, 2'd0, CT128, 1'b1);
        a1 = last_acc;
        send(CT128, 1'b1, 2'd0, PT, 1'b0);
        check_eq("throughput", 128'(last_acc - a1), 128'(11));
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(posedge clk); #2;
            if (busy && out_valid && rk_idx == 4'd0) ok = 1'b1;
        end
        check_eq("stall_reached", 128'(ok), 128'(1));
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of an AES-256 block.
        load_key(KEY256, 8);
        send(PT, 1'b0, 2'd2, CT256, 1'b1);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(posedge clk); #2;
            if (busy && rk_idx == 4'd5) ok = 1'b1;
        end
        check_eq("round5_reached", 128'(ok), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("post_reset_in_ready", 128'(in_ready), 128'(1));
        check_eq("post_reset_busy", 128'(busy), 128'(0));
        check_eq("post_reset_out_valid", 128'(out_valid), 128'(0));
        repeat (20) @(posedge clk);
        #1;

        load_key(KEY128, 4);
        send(PT, 1'b0, 2'd0, CT128, 1'b1); wait_drain();
        send(PT, 1'b0, 2'd3, CT128, 1'b1); wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
